task_answer_unpacker: RTL and testbench
=======================================

TASK_ANSWER_UNPACKER -- requirements
Module: task_answer_unpacker

Interface
REQ-001 Parameter FIFO_DEPTH, default 64, number of answer words buffered; power of two, >= 2.
REQ-002 Parameter WORD_WIDTH, default 32, answer word width; fixed at 32 (4 bytes per word).
REQ-003 i_clk  input  1  single clock; all logic on rising edge.
REQ-004 i_rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 i_flush  input  1  synchronous flush of all buffered and in-flight data.
REQ-006 i_word_data  input  32  packed answer word; byte 0 in bits [7:0], sent first.
REQ-007 i_word_valid  input  1  i_word_data qualifier; no backpressure honoured upstream.
REQ-008 i_word_last  input  1  marks final word of an answer packet.
REQ-009 i_size_in_bytes  input  32  answer packet length in bytes; sampled only on a valid last word.
REQ-010 o_word_ready  output  1  high when FIFO not full (status only).
REQ-011 o_byte_data  output  8  byte toward UART transmitter.
REQ-012 o_byte_valid  output  1  o_byte_data qualifier.
REQ-013 i_byte_ready  input  1  downstream accept; transfer when o_byte_valid and i_byte_ready both high.
REQ-014 o_byte_last  output  1  high with final byte of a packet.
REQ-015 o_overflow  output  1  sticky; word dropped because FIFO full.
REQ-016 o_busy  output  1  high when FIFO non-empty or FSM not IDLE.

Function
REQ-017 Write: i_word_valid high and FIFO not full -> store {data, last, nbytes}; nbytes 4 for non-last words.
REQ-018 Last word: nbytes = ((i_size_in_bytes - 1) mod 4) + 1; i_size_in_bytes = 0 -> nbytes = 4.
REQ-019 i_word_valid high while FIFO full -> word dropped, o_overflow set next cycle, FIFO unchanged.
REQ-020 FSM states IDLE, SEND; IDLE -> SEND when FIFO non-empty (pop into shift register, byte counter = nbytes).
REQ-021 SEND: o_byte_valid high, o_byte_data = shift register [7:0]; on transfer shift right 8, decrement counter.
REQ-022 SEND, transfer with counter = 1: FIFO non-empty -> pop next word same edge, stay SEND (no bubble); else -> IDLE.
REQ-023 o_byte_last = (counter = 1) and stored last flag; 0 otherwise.
REQ-024 Latency: word written at edge N -> o_byte_valid high after edge N+2 when FSM idle.
REQ-025 o_byte_data, o_byte_last stable while o_byte_valid high and i_byte_ready low.
REQ-026 Simultaneous FIFO write and pop permitted; full/empty evaluate correctly, count unchanged.
REQ-027 Write while full coinciding with pop: write rejected (full sampled before pop), overflow set.
REQ-028 Pointers wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
REQ-029 i_flush: next edge empties FIFO, FSM -> IDLE, o_byte_valid low; concurrent write dropped, no overflow flag.
REQ-030 i_flush does not clear o_overflow.

Reset
REQ-031 i_rst_n low -> immediately: FIFO empty, FSM IDLE, o_byte_valid 0, o_byte_last 0, o_byte_data 0, o_overflow 0, o_busy 0, o_word_ready 1.
REQ-032 Reset mid-packet discards remaining bytes; first post-reset output is the first byte of a newly written word.

Verification
REQ-033 Word 0x44332211 last, size 4, i_byte_ready=1 -> bytes 11,22,33,44 on consecutive cycles, last on 44.
REQ-034 Words 0x04030201, 0x08070605 last, size 6 -> bytes 01..06 back-to-back, last on 06, 07/08 never sent.
REQ-035 i_byte_ready toggling 1/0 -> every byte held stable while stalled, no loss or duplication.
REQ-036 FIFO_DEPTH=4, i_byte_ready=0, write 6 words -> o_word_ready low after 4th (plus popped word), o_overflow=1, first 5 words delivered intact.
REQ-037 Flush during SEND after 2 bytes -> o_byte_valid 0 next cycle, o_busy 0, o_overflow unchanged.
REQ-038 Assert i_rst_n low mid-packet, then write 0xAABBCCDD last size 1 -> single byte DD with last.

Source files
------------

// File: rtl/task_answer_unpacker.sv
// Answer word FIFO feeding a byte-serial unpacker toward the UART.
// Bytes leave LSB first; the last word of a packet may carry 1..4 bytes.
module task_answer_unpacker #(
  parameter int FIFO_DEPTH = 64,
  parameter int WORD_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_flush,
  input  logic [WORD_WIDTH-1:0] i_word_data,
  input  logic                  i_word_valid,
  input  logic                  i_word_last,
  input  logic [31:0]           i_size_in_bytes,
  output logic                  o_word_ready,
  output logic [7:0]            o_byte_data,
  output logic                  o_byte_valid,
  input  logic                  i_byte_ready,
  output logic                  o_byte_last,
  output logic                  o_overflow,
  output logic                  o_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [WORD_WIDTH-1:0] data;
    logic                  last;
    logic [2:0]            nbytes;
  } entry_t;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  entry_t          mem [FIFO_DEPTH];
  entry_t          wr_entry;
  entry_t          rd_entry;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            full;
  logic            empty;
  logic            wr_en;
  logic            pop;
  logic            xfer;
  logic            ne_q;
  logic [2:0]      tail_bytes;

  state_t                state;
  logic [WORD_WIDTH-1:0] shreg;
  logic [2:0]            cnt;
  logic                  last_q;
  logic                  valid_q;
  logic                  ovf_q;

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);

  // size 0 wraps to a full 4-byte tail word
  assign tail_bytes = 3'((i_size_in_bytes - 32'd1) & 32'd3) + 3'd1;

  assign wr_entry.data   = i_word_data;
  assign wr_entry.last   = i_word_last;
  assign wr_entry.nbytes = i_word_last ? tail_bytes : 3'd4;
  assign rd_entry        = mem[rd_ptr];

  assign wr_en = i_word_valid & ~full & ~i_flush;
  assign xfer  = valid_q & i_byte_ready;

  // IDLE uses the registered non-empty flag, adding one cycle of latency
  always_comb begin
    pop = 1'b0;
    if (!i_flush && !empty) begin
      unique case (state)
        IDLE: pop = ne_q;
        SEND: pop = xfer && (cnt == 3'd1);
        default: pop = 1'b0;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en)
      mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ne_q   <= 1'b0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ne_q   <= 1'b0;
    end else begin
      ne_q <= ~empty;
      if (wr_en)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      ovf_q <= 1'b0;
    else if (i_word_valid && full && !i_flush)
      ovf_q <= 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      valid_q <= 1'b0;
      shreg   <= '0;
      cnt     <= '0;
      last_q  <= 1'b0;
    end else if (i_flush) begin
      state   <= IDLE;
      valid_q <= 1'b0;
      cnt     <= '0;
      last_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            state   <= SEND;
            valid_q <= 1'b1;
            shreg   <= rd_entry.data;
            cnt     <= rd_entry.nbytes;
            last_q  <= rd_entry.last;
          end
        end
        SEND: begin
          if (xfer) begin
            if (cnt == 3'd1) begin
              if (pop) begin
                shreg  <= rd_entry.data;
                cnt    <= rd_entry.nbytes;
                last_q <= rd_entry.last;
              end else begin
                state   <= IDLE;
                valid_q <= 1'b0;
                cnt     <= '0;
                last_q  <= 1'b0;
              end
            end else begin
              shreg <= shreg >> 8;
              cnt   <= cnt - 3'd1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_word_ready = ~full;
  assign o_byte_data  = shreg[7:0];
  assign o_byte_valid = valid_q;
  assign o_byte_last  = valid_q & last_q & (cnt == 3'd1);
  assign o_overflow   = ovf_q;
  assign o_busy       = ~empty | (state != IDLE);

endmodule

// File: tb/tb_task_answer_unpacker.sv
// Scoreboard bench for task_answer_unpacker (FIFO_DEPTH=4).
// Expected bytes are queued at drive time and matched on each transfer.
module tb_task_answer_unpacker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_flush;
  logic [31:0] i_word_data;
  logic        i_word_valid;
  logic        i_word_last;
  logic [31:0] i_size_in_bytes;
  logic        o_word_ready;
  logic [7:0]  o_byte_data;
  logic        o_byte_valid;
  logic        i_byte_ready;
  logic        o_byte_last;
  logic        o_overflow;
  logic        o_busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [8:0] sb [$];
  int         xfer_cyc [$];
  logic [8:0] exp_b;
  logic [7:0] prev_d;
  logic       prev_l;
  logic       stalled = 1'b0;
  logic       toggle_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task_answer_unpacker #(
    .FIFO_DEPTH(4),
    .WORD_WIDTH(32)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_flush        (i_flush),
    .i_word_data    (i_word_data),
    .i_word_valid   (i_word_valid),
    .i_word_last    (i_word_last),
    .i_size_in_bytes(i_size_in_bytes),
    .o_word_ready   (o_word_ready),
    .o_byte_data    (o_byte_data),
    .o_byte_valid   (o_byte_valid),
    .i_byte_ready   (i_byte_ready),
    .o_byte_last    (o_byte_last),
    .o_overflow     (o_overflow),
    .o_busy         (o_busy)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] d, input logic last,
                          input int size);
    int n;
    if (!last)
      n = 4;
    else if (size % 4 == 0)
      n = 4;
    else
      n = size % 4;
    for (int i = 0; i < n; i++)
      sb.push_back({last && (i == n - 1), d[8*i +: 8]});
  endtask

  task automatic drive_word(input logic [31:0] d, input logic last,
                            input logic [31:0] size);
    i_word_valid    = 1'b1;
    i_word_data     = d;
    i_word_last     = last;
    i_size_in_bytes = size;
    @(posedge clk);
    #1;
    i_word_valid = 1'b0;
    i_word_last  = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while ((sb.size() != 0 || o_busy) && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("drain_sb", sb.size(), 0);
    check("drain_busy", o_busy, 0);
  endtask

  task automatic wait_valid(input int budget);
    int k = 0;
    while (!o_byte_valid && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("wait_valid", o_byte_valid, 1);
  endtask

  always @(posedge clk) begin
    if (toggle_en) begin
      #1;
      i_byte_ready = ~i_byte_ready;
    end
  end

  // stall stability plus scoreboard matching on every accepted byte
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled && o_byte_valid) begin
        check("hold_data", o_byte_data, prev_d);
        check("hold_last", o_byte_last, prev_l);
      end
      if (o_byte_valid && i_byte_ready) begin
        xfer_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          check("extra_byte", sb.size(), 1);
        end else begin
          exp_b = sb.pop_front();
          check("byte", {o_byte_last, o_byte_data}, exp_b);
        end
      end
      stalled = o_byte_valid && !i_byte_ready;
      prev_d  = o_byte_data;
      prev_l  = o_byte_last;
    end
  end

  initial begin
    rst_n           = 1'b0;
    i_flush         = 1'b0;
    i_word_data     = '0;
    i_word_valid    = 1'b0;
    i_word_last     = 1'b0;
    i_size_in_bytes = '0;
    i_byte_ready    = 1'b0;
    #2;
    check("rst_valid", o_byte_valid, 0);
    check("rst_last", o_byte_last, 0);
    check("rst_data", o_byte_data, 0);
    check("rst_ovf", o_overflow, 0);
    check("rst_busy", o_busy, 0);
    check("rst_wready", o_word_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single 4-byte word: latency and back-to-back bytes
    i_byte_ready = 1'b1;
    push_exp(32'h44332211, 1'b1, 4);
    drive_word(32'h44332211, 1'b1, 32'd4);
    check("lat_n0", o_byte_valid, 0);
    @(posedge clk);
    #1;
    check("lat_n1", o_byte_valid, 0);
    @(posedge clk);
    #1;
    check("lat_n2", o_byte_valid, 1);
    check("a_b0", o_byte_data, 32'h11);
    @(posedge clk);
    #1;
    check("a_b1", o_byte_data, 32'h22);
    @(posedge clk);
    #1;
    check("a_b2", o_byte_data, 32'h33);
    check("a_l2", o_byte_last, 0);
    @(posedge clk);
    #1;
    check("a_b3", o_byte_data, 32'h44);
    check("a_l3", o_byte_last, 1);
    wait_drain(20);

    // two words, 6-byte packet, no bubble between words
    xfer_cyc.delete();
    push_exp(32'h04030201, 1'b0, 0);
    push_exp(32'h08070605, 1'b1, 6);
    drive_word(32'h04030201, 1'b0, 32'd0);
    drive_word(32'h08070605, 1'b1, 32'd6);
    wait_drain(40);
    check("b_cnt", xfer_cyc.size(), 6);
    if (xfer_cyc.size() == 6)
      check("b_b2b", xfer_cyc[5] - xfer_cyc[0], 5);

    // toggling ready, 1-byte tail and size-0 tail
    toggle_en = 1'b1;
    push_exp(32'hDDCCBBAA, 1'b0, 0);
    push_exp(32'h00000099, 1'b1, 5);
    push_exp(32'h77665544, 1'b1, 0);
    drive_word(32'hDDCCBBAA, 1'b0, 32'd0);
    drive_word(32'h00000099, 1'b1, 32'd5);
    drive_word(32'h77665544, 1'b1, 32'd0);
    wait_drain(100);
    toggle_en = 1'b0;
    @(posedge clk);
    #2;

    // overflow with a stalled sink
    i_byte_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i < 5)
        push_exp(32'h10203040 + i * 32'h01010101, 1'b1, 4);
      drive_word(32'h10203040 + i * 32'h01010101, 1'b1, 32'd4);
    end
    check("d_wready", o_word_ready, 0);
    check("d_ovf", o_overflow, 1);
    i_byte_ready = 1'b1;
    wait_drain(100);
    check("d_wready_after", o_word_ready, 1);

    // flush after two bytes of a packet
    i_byte_ready = 1'b0;
    push_exp(32'h00004321, 1'b0, 0);
    sb.pop_back();
    sb.pop_back();
    drive_word(32'h87654321, 1'b1, 32'd4);
    wait_valid(10);
    i_byte_ready = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    i_byte_ready = 1'b0;
    i_flush      = 1'b1;
    i_word_valid = 1'b1;
    i_word_data  = 32'hDEADBEEF;
    i_word_last  = 1'b1;
    @(posedge clk);
    #1;
    i_flush      = 1'b0;
    i_word_valid = 1'b0;
    i_word_last  = 1'b0;
    check("e_valid", o_byte_valid, 0);
    check("e_busy", o_busy, 0);
    check("e_ovf", o_overflow, 1);
    check("e_wready", o_word_ready, 1);
    i_byte_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("e_idle", o_byte_valid, 0);
    check("e_sb", sb.size(), 0);

    // asynchronous reset in the middle of a packet
    i_byte_ready = 1'b0;
    sb.push_back({1'b0, 8'h88});
    drive_word(32'h55667788, 1'b1, 32'd4);
    wait_valid(10);
    i_byte_ready = 1'b1;
    @(posedge clk);
    #1;
    i_byte_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("f_valid", o_byte_valid, 0);
    check("f_last", o_byte_last, 0);
    check("f_data", o_byte_data, 0);
    check("f_busy", o_busy, 0);
    check("f_ovf", o_overflow, 0);
    check("f_wready", o_word_ready, 1);
    @(posedge clk);
    #1;
    rst_n        = 1'b1;
    i_byte_ready = 1'b1;
    push_exp(32'hAABBCCDD, 1'b1, 1);
    drive_word(32'hAABBCCDD, 1'b1, 32'd1);
    wait_drain(20);
    check("f_ovf_after", o_overflow, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
